// File: rtl/packet_frame_checker.sv
// Frame aligner and footer checker for the HEADER / payload / FOOTER test stream.
// Payloads sit in a commit/rollback FIFO; optional payload check via PKT_PATTERN_CHECK_EN.
module packet_frame_checker #(
    parameter logic [31:0] HEADER        = 32'hAAAAAAAA,
    parameter logic [31:0] FOOTER        = 32'hF0F0F0F0,
    parameter int          PAYLOAD_WORDS = 24,
    parameter int          FIFO_DEPTH    = 64,
    parameter int          CNT_W         = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      DATA_IN,
    input  logic             ENABLE,
    output logic [31:0]      M_TDATA,
    output logic             M_TVALID,
    input  logic             M_TREADY,
    output logic             M_TLAST,
    output logic             LOCKED,
    output logic [CNT_W-1:0] PKT_GOOD,
    output logic [CNT_W-1:0] PKT_BAD,
    output logic [CNT_W-1:0] PKT_DROP
`ifdef PKT_PATTERN_CHECK_EN
    ,
    output logic [CNT_W-1:0] PAT_ERR
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int NW = $clog2(PAYLOAD_WORDS + 1);

    typedef enum logic [1:0] {S_HUNT, S_PAYLOAD, S_SKIP, S_FOOTER} state_t;

    logic [31:0]      mem [FIFO_DEPTH];
    state_t           state_q;
    logic [PW-1:0]    wrPtr_q, wrCommit_q, rdPtr_q;
    logic [NW-1:0]    rdCnt_q, wordIdx_q;
    logic             locked_q;
    logic [CNT_W-1:0] pktGood_q, pktBad_q, pktDrop_q;

    logic [PW-1:0]    used, freeNow, freeRb;
    logic             headerSeen, rdFire, footerOk;
`ifdef PKT_PATTERN_CHECK_EN
    logic             patBad_q;
    logic [CNT_W-1:0] patErr_q;
    logic             wordMismatch;
`endif

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // freeRb is the room left once an in-flight frame has been rolled back
    always_comb begin
        used       = wrCommit_q - rdPtr_q;
        freeNow    = PW'(FIFO_DEPTH) - (wrPtr_q - rdPtr_q);
        freeRb     = PW'(FIFO_DEPTH) - used;
        headerSeen = ENABLE && (DATA_IN == HEADER);
        rdFire     = (used != '0) && M_TREADY;
`ifdef PKT_PATTERN_CHECK_EN
        wordMismatch = DATA_IN != {16'(2 * int'(wordIdx_q) + 1), 16'(2 * int'(wordIdx_q))};
        footerOk     = (DATA_IN == FOOTER) && !patBad_q;
`else
        footerOk     = (DATA_IN == FOOTER);
`endif
    end

    assign M_TVALID = (used != '0);
    assign M_TDATA  = mem[rdPtr_q[AW-1:0]];
    assign M_TLAST  = (rdCnt_q == NW'(PAYLOAD_WORDS - 1));
    assign LOCKED   = locked_q;
    assign PKT_GOOD = pktGood_q;
    assign PKT_BAD  = pktBad_q;
    assign PKT_DROP = pktDrop_q;
`ifdef PKT_PATTERN_CHECK_EN
    assign PAT_ERR  = patErr_q;
`endif

    always_ff @(posedge CLK) begin
        if (!RST && state_q == S_PAYLOAD) begin
            mem[wrPtr_q[AW-1:0]] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_HUNT;
            wrPtr_q    <= '0;
            wrCommit_q <= '0;
            rdPtr_q    <= '0;
            rdCnt_q    <= '0;
            wordIdx_q  <= '0;
            locked_q   <= 1'b0;
            pktGood_q  <= '0;
            pktBad_q   <= '0;
            pktDrop_q  <= '0;
`ifdef PKT_PATTERN_CHECK_EN
            patBad_q   <= 1'b0;
            patErr_q   <= '0;
`endif
        end else begin
            if (rdFire) begin
                rdPtr_q <= rdPtr_q + PW'(1);
                rdCnt_q <= (rdCnt_q == NW'(PAYLOAD_WORDS - 1)) ? '0 : rdCnt_q + NW'(1);
            end
            case (state_q)
                S_HUNT: begin
                    if (headerSeen) begin
                        wordIdx_q <= '0;
`ifdef PKT_PATTERN_CHECK_EN
                        patBad_q  <= 1'b0;
`endif
                        if (freeNow >= PW'(PAYLOAD_WORDS)) begin
                            state_q <= S_PAYLOAD;
                        end else begin
                            state_q   <= S_SKIP;
                            pktDrop_q <= satInc(pktDrop_q);
                        end
                    end
                end
                S_PAYLOAD: begin
                    wrPtr_q   <= wrPtr_q + PW'(1);
                    wordIdx_q <= wordIdx_q + NW'(1);
`ifdef PKT_PATTERN_CHECK_EN
                    if (wordMismatch) begin
                        patBad_q <= 1'b1;
                        patErr_q <= satInc(patErr_q);
                    end
`endif
                    if (wordIdx_q == NW'(PAYLOAD_WORDS - 1)) begin
                        state_q <= S_FOOTER;
                    end
                end
                S_SKIP: begin
                    wordIdx_q <= wordIdx_q + NW'(1);
                    if (wordIdx_q == NW'(PAYLOAD_WORDS)) begin
                        state_q <= S_HUNT;
                    end
                end
                S_FOOTER: begin
                    if (footerOk) begin
                        wrCommit_q <= wrPtr_q;
                        pktGood_q  <= satInc(pktGood_q);
                        locked_q   <= 1'b1;
                        state_q    <= S_HUNT;
                    end else begin
                        wrPtr_q  <= wrCommit_q;
                        pktBad_q <= satInc(pktBad_q);
                        locked_q <= 1'b0;
                        state_q  <= S_HUNT;
                        // A header landing in the footer slot starts the next frame immediately
                        if (headerSeen) begin
                            wordIdx_q <= '0;
`ifdef PKT_PATTERN_CHECK_EN
                            patBad_q  <= 1'b0;
`endif
                            if (freeRb >= PW'(PAYLOAD_WORDS)) begin
                                state_q <= S_PAYLOAD;
                            end else begin
                                state_q   <= S_SKIP;
                                pktDrop_q <= satInc(pktDrop_q);
                            end
                        end
                    end
                end
                default: state_q <= S_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_frame_checker.sv
// Testbench for packet_frame_checker: directed plan steps plus randomized frames,
// checked every cycle against a queue-based packet model.
module tb_packet_frame_checker;

    localparam int          PW    = 24;
    localparam int          DEPTH = 64;
    localparam int          CW    = 16;
    localparam logic [31:0] HDR   = 32'hAAAAAAAA;
    localparam logic [31:0] FTR   = 32'hF0F0F0F0;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [31:0]   DATA_IN = '0;
    logic          ENABLE = 1'b0;
    logic          M_TREADY = 1'b0;
    logic [31:0]   M_TDATA;
    logic          M_TVALID, M_TLAST, LOCKED;
    logic [CW-1:0] PKT_GOOD, PKT_BAD, PKT_DROP;
`ifdef PKT_PATTERN_CHECK_EN
    logic [CW-1:0] PAT_ERR;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        bit          last;
    } beat_t;

    beat_t       committed[$];
    logic [31:0] staged[$];
    bit          capturing;
    bit          frameMismatch;
    bit          mLocked;
    int          skipLeft;
    int          mGood, mBad, mDrop, mPatErr;

    packet_frame_checker dut (
        .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .ENABLE(ENABLE),
        .M_TDATA(M_TDATA), .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TLAST(M_TLAST),
        .LOCKED(LOCKED), .PKT_GOOD(PKT_GOOD), .PKT_BAD(PKT_BAD), .PKT_DROP(PKT_DROP)
`ifdef PKT_PATTERN_CHECK_EN
        , .PAT_ERR(PAT_ERR)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] patWord(input int n);
        return {16'(2 * n + 1), 16'(2 * n)};
    endfunction

    function automatic int satInc(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    function automatic bit rdyBit(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("tvalid", 32'(M_TVALID), 32'(committed.size() != 0));
        if (committed.size() != 0) begin
            checkValue("tdata", M_TDATA, committed[0].data);
            checkValue("tlast", 32'(M_TLAST), 32'(committed[0].last));
        end
        checkValue("locked", 32'(LOCKED), 32'(mLocked));
        checkValue("pkt_good", 32'(PKT_GOOD), 32'(mGood));
        checkValue("pkt_bad", 32'(PKT_BAD), 32'(mBad));
        checkValue("pkt_drop", 32'(PKT_DROP), 32'(mDrop));
`ifdef PKT_PATTERN_CHECK_EN
        checkValue("pat_err", 32'(PAT_ERR), 32'(mPatErr));
`endif
    endtask

    task automatic modelReset();
        committed.delete();
        staged.delete();
        capturing     = 1'b0;
        frameMismatch = 1'b0;
        mLocked       = 1'b0;
        skipLeft      = 0;
        mGood = 0; mBad = 0; mDrop = 0; mPatErr = 0;
    endtask

    task automatic tryHeader(input logic [31:0] w, input bit en, input int freeWords);
        if (en && w == HDR) begin
            if (freeWords >= PW) begin
                capturing     = 1'b1;
                frameMismatch = 1'b0;
            end else begin
                skipLeft = PW + 1;
                mDrop    = satInc(mDrop);
            end
        end
    endtask

    // One stream word as seen by the next rising edge; room is judged before that edge's read
    task automatic modelStep(input logic [31:0] w, input bit en, input bit rdy);
        bit pop = (committed.size() != 0) && rdy;
        if (capturing) begin
            if (staged.size() < PW) begin
`ifdef PKT_PATTERN_CHECK_EN
                if (w !== patWord(staged.size())) begin
                    frameMismatch = 1'b1;
                    mPatErr       = satInc(mPatErr);
                end
`endif
                staged.push_back(w);
            end else if (w == FTR && !frameMismatch) begin
                foreach (staged[i]) committed.push_back('{data: staged[i], last: (i == PW - 1)});
                staged.delete();
                mGood     = satInc(mGood);
                mLocked   = 1'b1;
                capturing = 1'b0;
            end else begin
                staged.delete();
                mBad      = satInc(mBad);
                mLocked   = 1'b0;
                capturing = 1'b0;
                tryHeader(w, en, DEPTH - committed.size());
            end
        end else if (skipLeft > 0) begin
            skipLeft--;
        end else begin
            tryHeader(w, en, DEPTH - committed.size());
        end
        if (pop) void'(committed.pop_front());
    endtask

    task automatic applyStimulus(input logic [31:0] w, input bit en, input bit rdy);
        @(negedge CLK);
        checkOutput();
        DATA_IN  = w;
        ENABLE   = en;
        M_TREADY = rdy;
        modelStep(w, en, rdy);
    endtask

    task automatic sendFrame(input logic [31:0] footer, input int badIdx, input logic [31:0] badVal,
                             input bit en, input int rdyPct, input int enDropAt);
        bit e = en;
        applyStimulus(HDR, e, rdyBit(rdyPct));
        for (int n = 0; n < PW; n++) begin
            if (n == enDropAt) e = 1'b0;
            applyStimulus((n == badIdx) ? badVal : patWord(n), e, rdyBit(rdyPct));
        end
        applyStimulus(footer, e, rdyBit(rdyPct));
    endtask

    task automatic resetDut();
        @(negedge CLK);
        RST     = 1'b1;
        DATA_IN = '0;
        @(posedge CLK);
        #1;
        checkValue("rst_tvalid", 32'(M_TVALID), 32'd0);
        checkValue("rst_locked", 32'(LOCKED), 32'd0);
        checkValue("rst_good", 32'(PKT_GOOD), 32'd0);
        checkValue("rst_bad", 32'(PKT_BAD), 32'd0);
        checkValue("rst_drop", 32'(PKT_DROP), 32'd0);
`ifdef PKT_PATTERN_CHECK_EN
        checkValue("rst_pat_err", 32'(PAT_ERR), 32'd0);
`endif
        @(negedge CLK);
        RST = 1'b0;
        modelReset();
        modelStep(DATA_IN, ENABLE, M_TREADY);
    endtask

    initial begin
        modelReset();
        resetDut();

        // Joined mid-frame: tail of a frame must be ignored
        for (int n = 10; n < PW; n++) applyStimulus(patWord(n), 1'b1, 1'b1);
        applyStimulus(FTR, 1'b1, 1'b1);

        sendFrame(FTR, -1, '0, 1'b1, 100, -1);
        applyStimulus('0, 1'b1, 1'b1);
        checkValue("t1_valid", 32'(M_TVALID), 32'd1);
        checkValue("t1_word0", M_TDATA, 32'h00010000);
        checkValue("t1_good", 32'(PKT_GOOD), 32'd1);
        checkValue("t1_locked", 32'(LOCKED), 32'd1);

        sendFrame(32'hF0F0F0F1, -1, '0, 1'b1, 100, -1);
        applyStimulus('0, 1'b1, 1'b1);
        checkValue("t2_bad", 32'(PKT_BAD), 32'd1);
        checkValue("t2_unlocked", 32'(LOCKED), 32'd0);
        sendFrame(FTR, -1, '0, 1'b1, 100, -1);
        applyStimulus('0, 1'b1, 1'b1);
        checkValue("t2_relocked", 32'(LOCKED), 32'd1);
        checkValue("t2_good", 32'(PKT_GOOD), 32'd2);
        repeat (30) applyStimulus('0, 1'b1, 1'b1);

        // Back-pressure: third frame finds only 16 free words
        repeat (3) sendFrame(FTR, -1, '0, 1'b1, 0, -1);
        applyStimulus('0, 1'b1, 1'b0);
        checkValue("t3_drop", 32'(PKT_DROP), 32'd1);
        checkValue("t3_good", 32'(PKT_GOOD), 32'd4);
        repeat (60) applyStimulus('0, 1'b1, 1'b1);
        checkValue("t3_drained", 32'(M_TVALID), 32'd0);
        sendFrame(FTR, -1, '0, 1'b1, 100, -1);
        applyStimulus('0, 1'b1, 1'b1);
        checkValue("t3_resume", 32'(PKT_GOOD), 32'd5);
        repeat (30) applyStimulus('0, 1'b1, 1'b1);

        sendFrame(FTR, -1, '0, 1'b0, 100, -1);
        applyStimulus('0, 1'b0, 1'b1);
        checkValue("t5_disabled", 32'(PKT_GOOD), 32'd5);
        sendFrame(FTR, -1, '0, 1'b1, 100, 5);
        sendFrame(FTR, -1, '0, 1'b0, 100, -1);
        applyStimulus('0, 1'b0, 1'b1);
        checkValue("t5_enable_drop", 32'(PKT_GOOD), 32'd6);
        repeat (30) applyStimulus('0, 1'b1, 1'b1);

`ifdef PKT_PATTERN_CHECK_EN
        sendFrame(FTR, 5, 32'h000B000B, 1'b1, 100, -1);
        applyStimulus('0, 1'b1, 1'b1);
        checkValue("t6_bad", 32'(PKT_BAD), 32'd2);
        checkValue("t6_pat_err", 32'(PAT_ERR), 32'd1);
        checkValue("t6_no_output", 32'(M_TVALID), 32'd0);
`endif

        // Random frames: gaps, bad footers, headers in the footer slot, corrupt words
        for (int f = 0; f < 40; f++) begin
            int          rdyPct = int'($urandom_range(100, 30));
            int          sel    = int'($urandom_range(9));
            logic [31:0] ftr    = (sel < 7) ? FTR : (sel == 7) ? (FTR ^ 32'h1) : HDR;
            int          badIdx = ($urandom_range(9) == 0) ? int'($urandom_range(PW - 1)) : -1;
            bit          en     = ($urandom_range(99) < 85);
            repeat ($urandom_range(3)) applyStimulus($urandom, 1'b1, rdyBit(rdyPct));
            sendFrame(ftr, badIdx, $urandom, en, rdyPct, -1);
        end
        repeat (80) applyStimulus('0, 1'b1, 1'b1);

        // Reset while a packet is buffered and another is mid-payload
        sendFrame(FTR, -1, '0, 1'b1, 0, -1);
        applyStimulus(HDR, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) applyStimulus(patWord(n), 1'b1, 1'b0);
        resetDut();
        sendFrame(FTR, -1, '0, 1'b1, 100, -1);
        repeat (30) applyStimulus('0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
